// File: rtl/button_debounce_multi_pkg.sv
// Purpose : shared state encoding and constants for the multi-channel button debouncer.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
package button_debounce_multi_pkg;

   // Per-channel hold tracker states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_LONG  = 2'd2
   } btn_state_t;

   // Nominal sample-strobe rate in Hz (one tick per millisecond).
   localparam int DEFAULT_TICK_HZ = 1000;

endpackage

// File: rtl/button_debounce_multi_channel.sv
// Purpose : one button channel: 2-FF synchroniser, stability counter, hold FSM, pulse registers.
// Latency : level and press/release pulse land 2 clk + STABLE_TICKS ticks after a raw change.
// Backpressure: none; pulses are single-clk and must be consumed when asserted.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   tick           sample strobe; gates every counter
//   btn_raw        asynchronous raw input, 1 = pressed
//   btn_level      debounced level
//   press_pulse    1-clk pulse on accepted 0->1
//   release_pulse  1-clk pulse on accepted 1->0
//   long_pulse     1-clk pulse when the hold reaches LONG_TICKS
//   repeat_pulse   1-clk pulse every REPEAT_TICKS after long_pulse (if REPEAT_EN)
module button_debounce_multi_channel
   import button_debounce_multi_pkg::*;
#(
   parameter int STABLE_TICKS = 3,
   parameter int LONG_TICKS   = 100,
   parameter int REPEAT_TICKS = 10,
   parameter bit REPEAT_EN    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int SW = $clog2(STABLE_TICKS + 1);
   localparam int HW = $clog2(LONG_TICKS + 1);
   localparam int RW = $clog2(REPEAT_TICKS + 1);

   // Compare against "last count before the threshold" so the increment never
   // needs an extra bit to hold the threshold value itself.
   localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_TICKS - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
   localparam logic [HW-1:0] LONG_HOLD = HW'(LONG_TICKS);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

   logic [1:0]    sync_q;
   logic [SW-1:0] stab_cnt, stab_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [RW-1:0] rep_cnt,  rep_nxt;
   btn_state_t    state,    state_nxt;
   logic          level_nxt;
   logic          press_nxt, release_nxt, long_nxt, repeat_nxt;
   logic          accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q        <= '0;
         stab_cnt      <= '0;
         hold_cnt      <= '0;
         rep_cnt       <= '0;
         state         <= ST_IDLE;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
      end else begin
         // Synchroniser runs every clk, independent of tick.
         sync_q        <= {sync_q[0], btn_raw};
         stab_cnt      <= stab_nxt;
         hold_cnt      <= hold_nxt;
         rep_cnt       <= rep_nxt;
         state         <= state_nxt;
         btn_level     <= level_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         long_pulse    <= long_nxt;
         repeat_pulse  <= repeat_nxt;
      end
   end

   always_comb begin
      stab_nxt    = stab_cnt;
      hold_nxt    = hold_cnt;
      rep_nxt     = rep_cnt;
      state_nxt   = state;
      level_nxt   = btn_level;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      repeat_nxt  = 1'b0;
      accept      = 1'b0;

      // Stability qualification: a differing level must persist STABLE_TICKS samples.
      if (tick) begin
         if (sync_q[1] != btn_level) begin
            if (stab_cnt == STAB_LAST) begin
               accept    = 1'b1;
               level_nxt = ~btn_level;
               stab_nxt  = '0;
            end else begin
               stab_nxt = stab_cnt + 1'b1;
            end
         end else begin
            stab_nxt = '0;
         end
      end

      // An accepted edge overrides any hold/repeat activity in the same clk.
      if (accept && !btn_level) begin
         press_nxt = 1'b1;
         state_nxt = ST_PRESS;
         hold_nxt  = '0;
         rep_nxt   = '0;
      end else if (accept) begin
         release_nxt = 1'b1;
         state_nxt   = ST_IDLE;
         hold_nxt    = '0;
         rep_nxt     = '0;
      end else if (tick) begin
         case (state)
            ST_PRESS: begin
               if (hold_cnt == LONG_LAST) begin
                  long_nxt  = 1'b1;
                  hold_nxt  = LONG_HOLD;
                  rep_nxt   = '0;
                  state_nxt = ST_LONG;
               end else begin
                  hold_nxt = hold_cnt + 1'b1;
               end
            end
            ST_LONG: begin
               // hold_cnt parks at LONG_TICKS; only the repeat counter cycles.
               if (rep_cnt == REP_LAST) begin
                  repeat_nxt = REPEAT_EN;
                  rep_nxt    = '0;
               end else begin
                  rep_nxt = rep_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/button_debounce_multi.sv
// Purpose : N-channel push-button debouncer with press/release/long/repeat event pulses.
// Latency : events appear 2 clk + STABLE_TICKS ticks after a raw edge; long/repeat counted in ticks.
// Backpressure: none; every output pulse is high for exactly one clk.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset (reset wins over tick)
//   tick           shared one-clk sample strobe
//   btn_raw        [N_BTN] asynchronous raw buttons, 1 = pressed
//   btn_level      [N_BTN] debounced levels
//   press_pulse, release_pulse, long_pulse, repeat_pulse  [N_BTN] per-channel event pulses
module button_debounce_multi
   import button_debounce_multi_pkg::*;
#(
   parameter int N_BTN        = 4,
   parameter int STABLE_TICKS = 3,
   parameter int LONG_TICKS   = 100,
   parameter int REPEAT_TICKS = 10,
   parameter int REPEAT_EN    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse,
   output logic [N_BTN-1:0] long_pulse,
   output logic [N_BTN-1:0] repeat_pulse
);

   // Channels are fully independent; only clk, rst and tick are shared.
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_debounce_multi_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS),
         .REPEAT_EN    (REPEAT_EN != 0)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .tick          (tick),
         .btn_raw       (btn_raw[i]),
         .btn_level     (btn_level[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .long_pulse    (long_pulse[i]),
         .repeat_pulse  (repeat_pulse[i])
      );
   end

endmodule
